// File: rtl/painterengine_gpu_raster_scanner.sv
// Triangle setup and raster-order scan feeding the point-in-triangle rasterizer.
// Emits one test point per cycle over the screen-clamped bounding box.
module painterengine_gpu_raster_scanner #(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int PIPE_LATENCY = 5
) (
  input  logic        i_wire_clock,
  input  logic        i_wire_resetn,
  input  logic        i_wire_start,
  input  logic [31:0] i_wire_point1,
  input  logic [31:0] i_wire_point2,
  input  logic [31:0] i_wire_point3,
  input  logic [31:0] i_wire_yes_color,
  input  logic [31:0] i_wire_no_color,
  input  logic        i_wire_hold,
  output logic        o_wire_busy,
  output logic        o_wire_done,
  output logic        o_wire_valid,
  output logic [31:0] o_wire_test_point,
  output logic [31:0] o_wire_point1,
  output logic [31:0] o_wire_point2,
  output logic [31:0] o_wire_point3,
  output logic [31:0] o_wire_yes_color,
  output logic [31:0] o_wire_no_color,
  output logic [31:0] o_wire_pixel_count
);

  typedef enum logic [2:0] {
    IDLE, BBOX, CLAMP, SCAN, DRAIN, DONE
  } state_e;

  localparam logic signed [16:0] XLIM = 17'(SCREEN_W - 1);
  localparam logic signed [16:0] YLIM = 17'(SCREEN_H - 1);
  localparam logic signed [16:0] ZERO = 17'sd0;

  state_e state_q, state_d;
  logic busy_q, busy_d, done_q, done_d, valid_q, valid_d;
  logic [31:0] tp_q, tp_d, cnt_q, cnt_d;
  logic [31:0] p1_q, p1_d, p2_q, p2_d, p3_q, p3_d;
  logic [31:0] yes_q, yes_d, no_q, no_d;
  logic signed [16:0] xmin_q, xmin_d, xmax_q, xmax_d;
  logic signed [16:0] ymin_q, ymin_d, ymax_q, ymax_d;
  logic signed [16:0] cx_q, cx_d, cy_q, cy_d;
  logic [15:0] drain_q, drain_d;
  logic signed [16:0] cxmin, cxmax, cymin, cymax;

  function automatic logic signed [16:0] sx(input logic [15:0] v);
    return {v[15], v};
  endfunction

  function automatic logic signed [16:0] smin3(
    input logic signed [16:0] a, b, c
  );
    logic signed [16:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic signed [16:0] smax3(
    input logic signed [16:0] a, b, c
  );
    logic signed [16:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  // Widening to 17 bits keeps every signed compare overflow-free.
  assign cxmin = (xmin_q < ZERO) ? ZERO : xmin_q;
  assign cymin = (ymin_q < ZERO) ? ZERO : ymin_q;
  assign cxmax = (xmax_q > XLIM) ? XLIM : xmax_q;
  assign cymax = (ymax_q > YLIM) ? YLIM : ymax_q;

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = 1'b0;
    tp_d    = tp_q;
    cnt_d   = cnt_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    p3_d    = p3_q;
    yes_d   = yes_q;
    no_d    = no_q;
    xmin_d  = xmin_q;
    xmax_d  = xmax_q;
    ymin_d  = ymin_q;
    ymax_d  = ymax_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    drain_d = drain_q;
    unique case (state_q)
      IDLE: begin
        if (i_wire_start) begin
          p1_d    = i_wire_point1;
          p2_d    = i_wire_point2;
          p3_d    = i_wire_point3;
          yes_d   = i_wire_yes_color;
          no_d    = i_wire_no_color;
          cnt_d   = 32'd0;
          busy_d  = 1'b1;
          state_d = BBOX;
        end
      end
      BBOX: begin
        xmin_d  = smin3(sx(p1_q[15:0]), sx(p2_q[15:0]), sx(p3_q[15:0]));
        xmax_d  = smax3(sx(p1_q[15:0]), sx(p2_q[15:0]), sx(p3_q[15:0]));
        ymin_d  = smin3(sx(p1_q[31:16]), sx(p2_q[31:16]), sx(p3_q[31:16]));
        ymax_d  = smax3(sx(p1_q[31:16]), sx(p2_q[31:16]), sx(p3_q[31:16]));
        state_d = CLAMP;
      end
      CLAMP: begin
        xmin_d = cxmin;
        xmax_d = cxmax;
        ymin_d = cymin;
        ymax_d = cymax;
        if (cxmin > cxmax || cymin > cymax) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          cx_d    = cxmin;
          cy_d    = cymin;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (!i_wire_hold) begin
          valid_d = 1'b1;
          tp_d    = {cy_q[15:0], cx_q[15:0]};
          cnt_d   = cnt_q + 32'd1;
          if (cx_q == xmax_q) begin
            if (cy_q == ymax_q) begin
              drain_d = 16'(PIPE_LATENCY);
              state_d = DRAIN;
            end else begin
              cx_d = xmin_q;
              cy_d = cy_q + 17'sd1;
            end
          end else begin
            cx_d = cx_q + 17'sd1;
          end
        end
      end
      DRAIN: begin
        if (drain_q == 16'd1) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          drain_d = drain_q - 16'd1;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      tp_q    <= '0;
      cnt_q   <= '0;
      p1_q    <= '0;
      p2_q    <= '0;
      p3_q    <= '0;
      yes_q   <= '0;
      no_q    <= '0;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymin_q  <= '0;
      ymax_q  <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      tp_q    <= tp_d;
      cnt_q   <= cnt_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      p3_q    <= p3_d;
      yes_q   <= yes_d;
      no_q    <= no_d;
      xmin_q  <= xmin_d;
      xmax_q  <= xmax_d;
      ymin_q  <= ymin_d;
      ymax_q  <= ymax_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      drain_q <= drain_d;
    end
  end

  assign o_wire_busy        = busy_q;
  assign o_wire_done        = done_q;
  assign o_wire_valid       = valid_q;
  assign o_wire_test_point  = tp_q;
  assign o_wire_point1      = p1_q;
  assign o_wire_point2      = p2_q;
  assign o_wire_point3      = p3_q;
  assign o_wire_yes_color   = yes_q;
  assign o_wire_no_color    = no_q;
  assign o_wire_pixel_count = cnt_q;

endmodule

// File: tb/tb_painterengine_gpu_raster_scanner.sv
// Randomized self-checking bench for the raster scanner.
// A box-enumeration model predicts the point stream, stalls and done timing.
module tb_painterengine_gpu_raster_scanner;

  localparam int W  = 640;
  localparam int H  = 480;
  localparam int PL = 5;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start = 1'b0;
  logic hold = 1'b0;
  logic [31:0] p1 = '0, p2 = '0, p3 = '0, yc = '0, nc = '0;
  logic busy, done, valid;
  logic [31:0] tp, op1, op2, op3, oyc, onc, pcnt;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  painterengine_gpu_raster_scanner #(
    .SCREEN_W(W), .SCREEN_H(H), .PIPE_LATENCY(PL)
  ) dut (
    .i_wire_clock(clk),
    .i_wire_resetn(rstn),
    .i_wire_start(start),
    .i_wire_point1(p1),
    .i_wire_point2(p2),
    .i_wire_point3(p3),
    .i_wire_yes_color(yc),
    .i_wire_no_color(nc),
    .i_wire_hold(hold),
    .o_wire_busy(busy),
    .o_wire_done(done),
    .o_wire_valid(valid),
    .o_wire_test_point(tp),
    .o_wire_point1(op1),
    .o_wire_point2(op2),
    .o_wire_point3(op3),
    .o_wire_yes_color(oyc),
    .o_wire_no_color(onc),
    .o_wire_pixel_count(pcnt)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pt(input int x, input int y);
    logic [15:0] xs, ys;
    xs = x[15:0];
    ys = y[15:0];
    return {ys, xs};
  endfunction

  function automatic int imin(input int a, b, c);
    int m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic int imax(input int a, b, c);
    int m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  task automatic build(input int ax, ay, bx, by, cx, cy);
    int x0, x1, y0, y1;
    exp_q.delete();
    x0 = imin(ax, bx, cx);
    x1 = imax(ax, bx, cx);
    y0 = imin(ay, by, cy);
    y1 = imax(ay, by, cy);
    if (x0 < 0) x0 = 0;
    if (y0 < 0) y0 = 0;
    if (x1 > W - 1) x1 = W - 1;
    if (y1 > H - 1) y1 = H - 1;
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++)
        exp_q.push_back(pt(x, y));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_tp"}, tp, 0);
    chk({tag, "_p1"}, op1, 0);
    chk({tag, "_p3"}, op3, 0);
    chk({tag, "_yes"}, oyc, 0);
    chk({tag, "_cnt"}, pcnt, 0);
  endtask

  task automatic run_job(input int ax, ay, bx, by, cx, cy,
                         input int hold_pct, input int hold_from,
                         input int hold_len, input bit drain_start,
                         input int abort_after);
    int n, emitted, last, hw, bound;
    bit hold_at, fin, ev, ed, ended;
    logic [31:0] s1, s2, s3, sy, sn;
    build(ax, ay, bx, by, cx, cy);
    n = exp_q.size();
    @(negedge clk);
    s1 = pt(ax, ay);
    s2 = pt(bx, by);
    s3 = pt(cx, cy);
    sy = $urandom;
    sn = $urandom;
    p1 = s1; p2 = s2; p3 = s3; yc = sy; nc = sn;
    start = 1'b1;
    hold = 1'b0;
    hold_at = 1'b0;
    emitted = 0;
    last = -1;
    hw = 0;
    fin = 1'b0;
    ended = 1'b0;
    bound = 3 * n + 60;
    for (int cyc = 0; cyc < bound; cyc++) begin
      @(negedge clk);
      if (cyc == 0) start = 1'b0;
      if (start && cyc > 0) start = 1'b0;
      ev = (cyc >= 3) && !hold_at && (emitted < n);
      chk("valid", valid, ev);
      if (ev) begin
        chk("point", tp, exp_q[emitted]);
        emitted++;
        if (emitted == n) last = cyc;
        if (hold_from >= 0 && emitted == hold_from) hw = hold_len;
      end
      ed = (n == 0) ? (cyc == 2) : (last >= 0 && cyc == last + PL);
      chk("done", done, ed);
      chk("busy", busy, !fin);
      if (fin) begin
        ended = 1'b1;
        break;
      end
      if (ed) fin = 1'b1;
      if (abort_after >= 0 && emitted == abort_after) begin
        rstn = 1'b0;
        hold = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        check_reset_outputs("abort_held");
        rstn = 1'b1;
        return;
      end
      if (drain_start && last >= 0 && cyc == last + 2) begin
        p1 = pt(1, 1); p2 = pt(9, 1); p3 = pt(1, 9);
        start = 1'b1;
      end
      if (hw > 0) begin
        hold = 1'b1;
        hw--;
      end else begin
        hold = ($urandom_range(99) < hold_pct);
      end
      hold_at = hold;
    end
    hold = 1'b0;
    if (!ended) chk("timeout", 0, 1);
    chk("pixel_count", pcnt, n);
    chk("emitted", emitted, n);
    chk("lat_p1", op1, s1);
    chk("lat_p2", op2, s2);
    chk("lat_p3", op3, s3);
    chk("lat_yes", oyc, sy);
    chk("lat_no", onc, sn);
    @(negedge clk);
    chk("idle_valid", valid, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    int bx, by;
    int v[6];
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rstn = 1'b1;
    @(negedge clk);
    run_job(2, 1, 5, 1, 2, 4, 0, -1, 0, 1'b0, -1);
    run_job(-10, -5, 3, -5, 3, 2, 0, -1, 0, 1'b0, -1);
    run_job(700, 10, 800, 10, 700, 20, 0, -1, 0, 1'b0, -1);
    run_job(0, 0, 3, 0, 0, 1, 0, 2, 3, 1'b0, -1);
    run_job(7, 7, 7, 7, 7, 7, 0, -1, 0, 1'b1, -1);
    run_job(2, 1, 5, 1, 2, 4, 0, -1, 0, 1'b0, 6);
    run_job(2, 1, 5, 1, 2, 4, 0, -1, 0, 1'b0, -1);
    run_job(630, 470, 660, 470, 630, 500, 20, -1, 0, 1'b0, -1);
    for (int j = 0; j < 40; j++) begin
      bx = int'($urandom_range(720)) - 40;
      by = int'($urandom_range(560)) - 40;
      for (int k = 0; k < 3; k++) begin
        v[2 * k]     = bx + int'($urandom_range(12)) - 6;
        v[2 * k + 1] = by + int'($urandom_range(12)) - 6;
      end
      run_job(v[0], v[1], v[2], v[3], v[4], v[5],
              int'($urandom_range(40)), -1, 0, j[0], -1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
